// File: rtl/jk_cmd_debounce.sv
// Debounces set/clear/toggle buttons and issues one-cycle J/K commands to the JK flip-flop bank.
// Latency: a clean press appears on enable DEBOUNCE+2 edges after the raw input is first sampled.
// No backpressure: the downstream flop accepts every strobe; collision losers are dropped, not held.
module jk_cmd_debounce #(
    parameter int DEBOUNCE = 1000
) (
    input  logic       clk,
    input  logic       Rn,
    input  logic       btn_set,
    input  logic       btn_clr,
    input  logic       btn_tog,
    output logic       J,
    output logic       K,
    output logic       enable,
    output logic       event_drop,
    output logic [2:0] stable
);

    localparam int CW = $clog2(DEBOUNCE);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE - 1);

    // Channel order everywhere is {tog, clr, set}.
    logic [2:0]    raw;
    logic [2:0]    sync1_q;
    logic [2:0]    sync2_q;
    logic [2:0]    stable_q;
    logic [2:0]    stable_d;
    logic [2:0]    stable_prev_q;
    logic [CW-1:0] cnt_q [3];
    logic [CW-1:0] cnt_d [3];
    logic [2:0]    rise;

    logic          j_q, j_d;
    logic          k_q, k_d;
    logic          en_q, en_d;
    logic          drop_q, drop_d;

    assign raw = {btn_tog, btn_clr, btn_set};

    always_ff @(posedge clk or negedge Rn) begin
        if (!Rn) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
        end
    end

    // Any cycle where the synchronised level agrees with the stable level restarts the count.
    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < 3; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    stable_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge Rn) begin
        if (!Rn) begin
            stable_q      <= '0;
            stable_prev_q <= '0;
            for (int i = 0; i < 3; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            stable_q      <= stable_d;
            stable_prev_q <= stable_q;
            for (int i = 0; i < 3; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign rise = stable_q & ~stable_prev_q;

    // Priority clr > set > tog; any other simultaneous rise is reported as dropped.
    always_comb begin
        j_d    = 1'b0;
        k_d    = 1'b0;
        en_d   = 1'b0;
        drop_d = 1'b0;
        if (rise[1]) begin
            k_d    = 1'b1;
            en_d   = 1'b1;
            drop_d = rise[0] | rise[2];
        end else if (rise[0]) begin
            j_d    = 1'b1;
            en_d   = 1'b1;
            drop_d = rise[2];
        end else if (rise[2]) begin
            j_d    = 1'b1;
            k_d    = 1'b1;
            en_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge Rn) begin
        if (!Rn) begin
            j_q    <= 1'b0;
            k_q    <= 1'b0;
            en_q   <= 1'b0;
            drop_q <= 1'b0;
        end else begin
            j_q    <= j_d;
            k_q    <= k_d;
            en_q   <= en_d;
            drop_q <= drop_d;
        end
    end

    assign J          = j_q;
    assign K          = k_q;
    assign enable     = en_q;
    assign event_drop = drop_q;
    assign stable     = stable_q;

endmodule

// File: tb/tb_jk_cmd_debounce.sv
// Bench for jk_cmd_debounce with DEBOUNCE=4: directed scenarios plus random button activity,
// all compared cycle by cycle against a history-window reference model.
module tb_jk_cmd_debounce;

    localparam int DEB = 4;

    logic       clk = 1'b0;
    logic       Rn  = 1'b0;
    logic       btn_set = 1'b0;
    logic       btn_clr = 1'b0;
    logic       btn_tog = 1'b0;
    logic       J, K, enable, event_drop;
    logic [2:0] stable;

    int n_tests = 0;
    int n_fail  = 0;

    jk_cmd_debounce #(.DEBOUNCE(DEB)) dut (
        .clk        (clk),
        .Rn         (Rn),
        .btn_set    (btn_set),
        .btn_clr    (btn_clr),
        .btn_tog    (btn_tog),
        .J          (J),
        .K          (K),
        .enable     (enable),
        .event_drop (event_drop),
        .stable     (stable)
    );

    always #5 clk = ~clk;

    // Reference model: raw delayed two edges gives the synchronised level; a channel's stable
    // level flips when the last DEB evaluated levels since its previous flip all disagree with it.
    logic [2:0] m_r1, m_r2, m_stable, m_prev;
    logic       m_j, m_k, m_en, m_drop;
    logic [2:0] hist[$];
    int         since [3];

    task automatic model_reset();
        m_r1 = '0; m_r2 = '0; m_stable = '0; m_prev = '0;
        m_j = 0; m_k = 0; m_en = 0; m_drop = 0;
        hist.delete();
        for (int c = 0; c < 3; c++) since[c] = 0;
    endtask

    task automatic model_edge();
        logic [2:0] rise;
        logic [2:0] s;
        logic [2:0] e;
        bit         all_diff;
        if (!Rn) begin
            model_reset();
            return;
        end
        rise   = m_stable & ~m_prev;
        m_en   = |rise;
        m_j    = 0;
        m_k    = 0;
        m_drop = 0;
        if (rise[1]) begin
            m_k = 1; m_drop = rise[0] | rise[2];
        end else if (rise[0]) begin
            m_j = 1; m_drop = rise[2];
        end else if (rise[2]) begin
            m_j = 1; m_k = 1;
        end
        m_prev = m_stable;
        s = m_r2;
        hist.push_back(s);
        if (hist.size() > 32) void'(hist.pop_front());
        for (int c = 0; c < 3; c++) begin
            since[c]++;
            if (since[c] >= DEB) begin
                all_diff = 1;
                for (int j = 0; j < DEB; j++) begin
                    e = hist[hist.size() - 1 - j];
                    if (e[c] == m_stable[c]) all_diff = 0;
                end
                if (all_diff) begin
                    m_stable[c] = s[c];
                    since[c] = 0;
                end
            end
        end
        m_r2 = m_r1;
        m_r1 = {btn_tog, btn_clr, btn_set};
    endtask

    // Drive buttons {tog, clr, set} at the falling edge, clock once, sample 1 time unit later.
    task automatic tick(input logic [2:0] b);
        @(negedge clk);
        {btn_tog, btn_clr, btn_set} = b;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic go_reset();
        Rn = 1'b0;
        tick(3'b000);
        tick(3'b000);
        Rn = 1'b1;
    endtask

    task automatic test_reset();
        logic [2:0] r;
        Rn = 1'b0;
        for (int k = 0; k < 8; k++) begin
            r = 3'($urandom);
            tick(r);
            n_tests++;
            if ({J, K, enable, event_drop, stable} !== 7'b0) begin
                n_fail++;
                $display("FAIL reset_hold k=%0d got %b exp 0000000", k, {J, K, enable, event_drop, stable});
            end
        end
        Rn = 1'b1;
        for (int k = 0; k < 7; k++) tick(3'b111);
        n_tests++;
        if ({J, K, enable, event_drop, stable} !== 7'b0111111) begin
            n_fail++;
            $display("FAIL reset_pre_async got %b exp 0111111", {J, K, enable, event_drop, stable});
        end
        #2;
        Rn = 1'b0;
        #1;
        n_tests++;
        if ({J, K, enable, event_drop, stable} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_async got %b exp 0000000", {J, K, enable, event_drop, stable});
        end
        model_reset();
        tick(3'b000);
        tick(3'b000);
        Rn = 1'b1;
    endtask

    task automatic test_set_hold();
        go_reset();
        for (int k = 0; k < 25; k++) begin
            tick(k < 14 ? 3'b001 : 3'b000);
            n_tests++;
            if ({J, K, enable, event_drop, stable} !== {m_j, m_k, m_en, m_drop, m_stable}) begin
                n_fail++;
                $display("FAIL set_hold_model k=%0d got %b exp %b", k,
                         {J, K, enable, event_drop, stable}, {m_j, m_k, m_en, m_drop, m_stable});
            end
            n_tests++;
            if ({J, K, enable} !== ((k == 6) ? 3'b101 : 3'b000)) begin
                n_fail++;
                $display("FAIL set_hold_latency k=%0d got JKen=%b exp %b", k, {J, K, enable},
                         (k == 6) ? 3'b101 : 3'b000);
            end
        end
    endtask

    task automatic test_glitch();
        logic [6:0] pat;
        pat = 7'b1111011;
        go_reset();
        for (int k = 0; k < 18; k++) begin
            tick({(k < 7) ? pat[k] : 1'b1, 2'b00});
            n_tests++;
            if ({J, K, enable, event_drop, stable} !== {m_j, m_k, m_en, m_drop, m_stable}) begin
                n_fail++;
                $display("FAIL glitch_model k=%0d got %b exp %b", k,
                         {J, K, enable, event_drop, stable}, {m_j, m_k, m_en, m_drop, m_stable});
            end
            n_tests++;
            if ({J, K, enable} !== ((k == 9) ? 3'b111 : 3'b000)) begin
                n_fail++;
                $display("FAIL glitch_latency k=%0d got JKen=%b exp %b", k, {J, K, enable},
                         (k == 9) ? 3'b111 : 3'b000);
            end
        end
    endtask

    task automatic test_collision();
        go_reset();
        for (int k = 0; k < 14; k++) begin
            tick(3'b011);
            n_tests++;
            if ({J, K, enable, event_drop, stable} !== {m_j, m_k, m_en, m_drop, m_stable}) begin
                n_fail++;
                $display("FAIL collision_model k=%0d got %b exp %b", k,
                         {J, K, enable, event_drop, stable}, {m_j, m_k, m_en, m_drop, m_stable});
            end
            n_tests++;
            if ({J, K, enable, event_drop} !== ((k == 6) ? 4'b0111 : 4'b0000)) begin
                n_fail++;
                $display("FAIL collision_out k=%0d got JKen_drop=%b exp %b", k,
                         {J, K, enable, event_drop}, (k == 6) ? 4'b0111 : 4'b0000);
            end
        end
        for (int k = 0; k < 8; k++) tick(3'b000);
    endtask

    task automatic test_back_to_back();
        logic [2:0] exp_jke;
        go_reset();
        for (int k = 0; k < 14; k++) begin
            tick((k == 0) ? 3'b010 : 3'b110);
            n_tests++;
            if ({J, K, enable, event_drop, stable} !== {m_j, m_k, m_en, m_drop, m_stable}) begin
                n_fail++;
                $display("FAIL b2b_model k=%0d got %b exp %b", k,
                         {J, K, enable, event_drop, stable}, {m_j, m_k, m_en, m_drop, m_stable});
            end
            exp_jke = (k == 6) ? 3'b011 : (k == 7) ? 3'b111 : 3'b000;
            n_tests++;
            if ({J, K, enable} !== exp_jke) begin
                n_fail++;
                $display("FAIL b2b_out k=%0d got JKen=%b exp %b", k, {J, K, enable}, exp_jke);
            end
        end
        for (int k = 0; k < 8; k++) tick(3'b000);
    endtask

    task automatic test_reset_mid();
        go_reset();
        for (int k = 0; k < 20; k++) begin
            Rn = (k == 3 || k == 4) ? 1'b0 : 1'b1;
            tick(3'b001);
            n_tests++;
            if ({J, K, enable, event_drop, stable} !== {m_j, m_k, m_en, m_drop, m_stable}) begin
                n_fail++;
                $display("FAIL reset_mid_model k=%0d got %b exp %b", k,
                         {J, K, enable, event_drop, stable}, {m_j, m_k, m_en, m_drop, m_stable});
            end
            n_tests++;
            if (enable !== (k == 11)) begin
                n_fail++;
                $display("FAIL reset_mid_latency k=%0d got enable=%b exp %b", k, enable, (k == 11));
            end
        end
        Rn = 1'b1;
        for (int k = 0; k < 8; k++) tick(3'b000);
    endtask

    task automatic test_random();
        logic [2:0] lvl;
        int         strobes;
        lvl = '0;
        strobes = 0;
        for (int k = 0; k < 1500; k++) begin
            for (int c = 0; c < 3; c++) begin
                if ($urandom_range(0, 5) == 0) lvl[c] = ~lvl[c];
            end
            tick(lvl);
            if (m_en) strobes++;
            n_tests++;
            if ({J, K, enable, event_drop, stable} !== {m_j, m_k, m_en, m_drop, m_stable}) begin
                n_fail++;
                $display("FAIL random k=%0d in=%b got %b exp %b", k, lvl,
                         {J, K, enable, event_drop, stable}, {m_j, m_k, m_en, m_drop, m_stable});
            end
        end
        n_tests++;
        if (strobes == 0) begin
            n_fail++;
            $display("FAIL random_activity got %0d strobes exp >0", strobes);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_set_hold();
        test_glitch();
        test_collision();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
